// File: rtl/ground_scroller_if.sv
// Bundle of the ground scroller's pixel-lookup, frame-strobe and pattern-write signals.
// master drives the VGA position, game state and pattern writes; slave is the scroller.
interface ground_scroller_if #(
  parameter int unsigned TILE_W    = 40,
  parameter int unsigned TILE_ROWS = 8
);
  localparam int unsigned PosW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned RowW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  logic [8:0]        row_addr;
  logic [9:0]        col_addr;
  logic              game_status;
  logic              fresh;
  logic              pat_we;
  logic [RowW-1:0]   pat_row;
  logic [TILE_W-1:0] pat_data;
  logic [PosW-1:0]   ground_position;
  logic [3:0]        speed;
  logic              px;

  modport master (
    output row_addr, col_addr, game_status, fresh, pat_we, pat_row, pat_data,
    input  ground_position, speed, px
  );

  modport slave (
    input  row_addr, col_addr, game_status, fresh, pat_we, pat_row, pat_data,
    output ground_position, speed, px
  );
endinterface

// File: rtl/ground_scroller.sv
// Scrolling tiled ground band with a writable pattern. When GROUND_SPEEDUP_EN is defined
// the scroll speed ramps up every SPEED_STEP_FRAMES frames; otherwise it stays at 1.
module ground_scroller #(
  parameter int unsigned TILE_W            = 40,
  parameter int unsigned TILE_ROWS         = 8,
  parameter int unsigned Y_TOP             = 400,
  parameter int unsigned SPEED_MAX         = 7,
  parameter int unsigned SPEED_STEP_FRAMES = 256,
  parameter logic [TILE_W*TILE_ROWS-1:0] DEFAULT_PATTERN =
    (TILE_W*TILE_ROWS)'({TILE_W{1'b1}}) << (2 * TILE_W)
) (
  input  logic               clk,
  input  logic               N_rst,
  ground_scroller_if.slave   bus
);
  localparam int unsigned PosW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int unsigned RowW = (TILE_ROWS > 1) ? $clog2(TILE_ROWS) : 1;

  if (SPEED_MAX < 1 || SPEED_MAX > 15 || SPEED_MAX >= TILE_W || SPEED_STEP_FRAMES < 1)
  begin : g_param_check
    $error("ground_scroller: invalid speed parameters");
  end

  logic              fresh_q;
  logic              fall;
  logic [PosW-1:0]   pos_q, pos_d;
  logic              px_q, px_d;
  logic [3:0]        speed_cur;
  logic [TILE_W-1:0] pat_q [TILE_ROWS];
  logic [31:0]       pos_sum, col_sum, row_off;

  assign fall = fresh_q & ~bus.fresh;

  // Speed never reaches TILE_W, so one subtraction keeps the offset in range.
  always_comb begin
    pos_sum = 32'(pos_q) + 32'(speed_cur);
    pos_d   = pos_q;
    if (fall && bus.game_status) begin
      pos_d = (pos_sum >= TILE_W) ? PosW'(pos_sum - TILE_W) : PosW'(pos_sum);
    end
  end

  always_comb begin
    row_off = 32'(bus.row_addr) - Y_TOP;
    col_sum = (32'(bus.col_addr) + 32'(pos_q)) % TILE_W;
    px_d    = 1'b0;
    if (bus.game_status && (32'(bus.row_addr) >= Y_TOP) && (row_off < TILE_ROWS)) begin
      px_d = pat_q[RowW'(row_off)][PosW'(col_sum)];
    end
  end

  always_ff @(posedge clk) begin
    if (!N_rst) begin
      fresh_q <= 1'b1;
      pos_q   <= '0;
      px_q    <= 1'b0;
      for (int unsigned r = 0; r < TILE_ROWS; r++) begin
        pat_q[r] <= DEFAULT_PATTERN[r*TILE_W +: TILE_W];
      end
    end else begin
      fresh_q <= bus.fresh;
      pos_q   <= pos_d;
      px_q    <= px_d;
      if (bus.pat_we && (32'(bus.pat_row) < TILE_ROWS)) begin
        pat_q[bus.pat_row] <= bus.pat_data;
      end
    end
  end

`ifdef GROUND_SPEEDUP_EN
  localparam int unsigned CntW = (SPEED_STEP_FRAMES > 1) ? $clog2(SPEED_STEP_FRAMES) : 1;

  logic [3:0]      speed_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!N_rst || !bus.game_status) begin
      speed_q <= 4'd1;
      cnt_q   <= '0;
    end else if (fall) begin
      if (cnt_q == CntW'(SPEED_STEP_FRAMES - 1)) begin
        cnt_q <= '0;
        if (32'(speed_q) < SPEED_MAX) begin
          speed_q <= speed_q + 4'd1;
        end
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign speed_cur = speed_q;
`else
  assign speed_cur = 4'd1;
`endif

  assign bus.ground_position = pos_q;
  assign bus.speed           = speed_cur;
  assign bus.px              = px_q;
endmodule

// File: tb/tb_ground_scroller.sv
// Directed bench for ground_scroller: table of pixel lookups plus hand-written
// sequences for scrolling, speed ramp, pattern writes and reset override.
module tb_ground_scroller;
  localparam int unsigned TileW  = 40;
  localparam int unsigned TileRs = 8;

  logic clk = 1'b0;
  logic N_rst;
  always #5 clk = ~clk;

  ground_scroller_if #(.TILE_W(TileW), .TILE_ROWS(TileRs)) bus ();

  ground_scroller #(
    .TILE_W(TileW), .TILE_ROWS(TileRs), .Y_TOP(400), .SPEED_MAX(7), .SPEED_STEP_FRAMES(4)
  ) dut (
    .clk  (clk),
    .N_rst(N_rst),
    .bus  (bus)
  );

  typedef struct {
    logic [8:0] row;
    logic [9:0] col;
    logic       gs;
    logic       exp_px;
  } vec_t;

  vec_t vecs[10];
  int n_tests = 0;
  int n_fail  = 0;
  int pos_m, spd_m, cnt_m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame: fresh high for a cycle, then low; the fall lands on the second edge.
  task automatic frame();
    bus.fresh = 1'b1;
    tick();
    bus.fresh = 1'b0;
    tick();
    if (bus.game_status) begin
      pos_m = (pos_m + spd_m) % TileW;
`ifdef GROUND_SPEEDUP_EN
      if (cnt_m == 3) begin
        cnt_m = 0;
        if (spd_m < 7) spd_m++;
      end else begin
        cnt_m++;
      end
`endif
    end else begin
      spd_m = 1;
      cnt_m = 0;
    end
  endtask

  task automatic pause();
    bus.game_status = 1'b0;
    tick();
    bus.game_status = 1'b1;
    spd_m = 1;
    cnt_m = 0;
  endtask

  task automatic do_reset();
    bus.fresh  = 1'b1;
    bus.pat_we = 1'b0;
    N_rst = 1'b0;
    tick();
    N_rst = 1'b1;
    pos_m = 0;
    spd_m = 1;
    cnt_m = 0;
  endtask

  task automatic lookup(input int row, input int col);
    bus.row_addr = 9'(row);
    bus.col_addr = 10'(col);
    tick();
  endtask

  initial begin
    vecs[0] = '{row: 9'd402, col: 10'd5,    gs: 1'b1, exp_px: 1'b1};
    vecs[1] = '{row: 9'd401, col: 10'd5,    gs: 1'b1, exp_px: 1'b0};
    vecs[2] = '{row: 9'd402, col: 10'd0,    gs: 1'b1, exp_px: 1'b1};
    vecs[3] = '{row: 9'd402, col: 10'd1023, gs: 1'b1, exp_px: 1'b1};
    vecs[4] = '{row: 9'd403, col: 10'd5,    gs: 1'b1, exp_px: 1'b0};
    vecs[5] = '{row: 9'd399, col: 10'd5,    gs: 1'b1, exp_px: 1'b0};
    vecs[6] = '{row: 9'd407, col: 10'd39,   gs: 1'b1, exp_px: 1'b0};
    vecs[7] = '{row: 9'd408, col: 10'd5,    gs: 1'b1, exp_px: 1'b0};
    vecs[8] = '{row: 9'd402, col: 10'd5,    gs: 1'b0, exp_px: 1'b0};
    vecs[9] = '{row: 9'd100, col: 10'd5,    gs: 1'b1, exp_px: 1'b0};

    bus.row_addr    = 9'd402;
    bus.col_addr    = 10'd5;
    bus.game_status = 1'b1;
    bus.fresh       = 1'b1;
    bus.pat_we      = 1'b0;
    bus.pat_row     = '0;
    bus.pat_data    = '0;
    N_rst = 1'b0;
    tick();
    tick();
    check("reset_pos", int'(bus.ground_position), 0);
    check("reset_speed", int'(bus.speed), 1);
    check("reset_px", int'(bus.px), 0);
    N_rst = 1'b1;
    pos_m = 0;
    spd_m = 1;
    cnt_m = 0;

    // Pixel lookup table at offset 0 with the default pattern
    for (int i = 0; i < 10; i++) begin
      bus.game_status = vecs[i].gs;
      lookup(int'(vecs[i].row), int'(vecs[i].col));
      check($sformatf("px_vec%0d", i), int'(bus.px), int'(vecs[i].exp_px));
    end
    bus.game_status = 1'b1;
    spd_m = 1;
    cnt_m = 0;

    // Reach offset 39 at speed 1, then wrap
    for (int k = 0; k < 39; k++) begin
      frame();
      if (k % 3 == 2) pause();
    end
    check("pos_39", int'(bus.ground_position), 39);
    check("speed_1_at_39", int'(bus.speed), 1);
    frame();
    check("pos_wrap", int'(bus.ground_position), 0);
    repeat (100) tick();
    check("hold_fresh_low", int'(bus.ground_position), 0);
    bus.fresh = 1'b1;
    repeat (100) tick();
    check("hold_fresh_high", int'(bus.ground_position), 0);

    // Pattern write and offset lookup
    do_reset();
    bus.game_status = 1'b1;
    bus.pat_we   = 1'b1;
    bus.pat_row  = 3'd0;
    bus.pat_data = 40'd8;
    tick();
    bus.pat_we = 1'b0;
    lookup(400, 43);
    check("pat_col43", int'(bus.px), 1);
    lookup(400, 44);
    check("pat_col44", int'(bus.px), 0);
    lookup(400, 3);
    check("pat_col3", int'(bus.px), 1);
    repeat (7) frame();
    check("pos_after_7", int'(bus.ground_position), pos_m);
    lookup(400, (3 - pos_m + 40) % 40);
    check("px_offset_hit", int'(bus.px), 1);
    lookup(400, (4 - pos_m + 40) % 40);
    check("px_offset_miss", int'(bus.px), 0);

    // Stopped: position holds, pattern writes still land and survive restart
    bus.game_status = 1'b0;
    frame();
    check("stopped_hold", int'(bus.ground_position), pos_m);
    bus.pat_we   = 1'b1;
    bus.pat_row  = 3'd1;
    bus.pat_data = 40'd1;
    tick();
    bus.pat_we = 1'b0;
    lookup(401, 0);
    check("px_stopped", int'(bus.px), 0);
    bus.game_status = 1'b1;
    spd_m = 1;
    cnt_m = 0;
    lookup(401, (40 - pos_m) % 40);
    check("restart_row1", int'(bus.px), 1);
    lookup(400, (3 - pos_m + 40) % 40);
    check("restart_row0", int'(bus.px), 1);

    // Speed ramp
    do_reset();
    bus.game_status = 1'b1;
`ifdef GROUND_SPEEDUP_EN
    repeat (4) frame();
    check("speed_after_4", int'(bus.speed), 2);
    check("pos_after_4", int'(bus.ground_position), 4);
    repeat (24) frame();
    check("speed_after_28", int'(bus.speed), 7);
    repeat (8) frame();
    check("speed_after_36", int'(bus.speed), 7);
    check("pos_after_36", int'(bus.ground_position), 8);
    pause();
    check("speed_stop", int'(bus.speed), 1);
    repeat (3) frame();
    check("cnt_cleared", int'(bus.speed), 1);
    frame();
    check("speed_again", int'(bus.speed), 2);
`else
    repeat (36) frame();
    check("speed_const", int'(bus.speed), 1);
    check("pos_after_36", int'(bus.ground_position), 36);
`endif

    // Reset overrides a fall and a pattern write in the same cycle
    repeat (5) frame();
    bus.fresh = 1'b1;
    tick();
    N_rst = 1'b0;
    bus.fresh    = 1'b0;
    bus.pat_we   = 1'b1;
    bus.pat_row  = 3'd2;
    bus.pat_data = '0;
    bus.row_addr = 9'd402;
    bus.col_addr = 10'd5;
    tick();
    check("rst_pos", int'(bus.ground_position), 0);
    check("rst_speed", int'(bus.speed), 1);
    check("rst_px", int'(bus.px), 0);
    N_rst = 1'b1;
    bus.pat_we = 1'b0;
    bus.fresh  = 1'b1;
    lookup(402, 5);
    check("rst_row2", int'(bus.px), 1);
    lookup(400, 43);
    check("rst_row0", int'(bus.px), 0);
    check("rst_no_residue", int'(bus.ground_position), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ground_scroller.md
GROUND_SCROLLER -- requirements
Module: ground_scroller

Interface
REQ-001 Parameter TILE_W, default 40: width in pixels of one pattern tile and the horizontal repeat period.
REQ-002 Parameter TILE_ROWS, default 8: number of pattern rows drawn.
REQ-003 Parameter Y_TOP, default 400: first screen row of the ground band.
REQ-004 Parameter SPEED_MAX, default 7: speed ceiling; the block SHALL require 1 <= SPEED_MAX <= 15 and SPEED_MAX < TILE_W.
REQ-005 Parameter SPEED_STEP_FRAMES, default 256: scroll frames per speed increment.
REQ-006 Parameter DEFAULT_PATTERN, width TILE_W*TILE_ROWS, default: row 2 all ones, all other rows zero.
REQ-007 clk  in  1  single clock; all state updates on its rising edge.
REQ-008 N_rst  in  1  reset, synchronous, active-low.
REQ-009 row_addr  in  9  current VGA row.
REQ-010 col_addr  in  10  current VGA column.
REQ-011 game_status  in  1  1 = running, 0 = stopped.
REQ-012 fresh  in  1  frame strobe; each falling edge marks one frame.
REQ-013 pat_we  in  1  pattern-row write enable.
REQ-014 pat_row  in  clog2(TILE_ROWS)  pattern row to write.
REQ-015 pat_data  in  TILE_W  new row contents; bit i = tile column i.
REQ-016 ground_position  out  clog2(TILE_W)  current scroll offset.
REQ-017 speed  out  4  pixels advanced per frame.
REQ-018 px  out  1  ground pixel for the current row/column.

Function
REQ-019 Pattern storage SHALL be TILE_ROWS x TILE_W bits; row r, column c = DEFAULT_PATTERN bit r*TILE_W+c after reset.
REQ-020 fresh SHALL be registered into fresh_q; frame event fall = fresh_q & ~fresh, one clk wide; fresh is treated as synchronous to clk.
REQ-021 On fall with game_status=1: ground_position <= ground_position+speed, minus TILE_W when the sum >= TILE_W (position stays in 0..TILE_W-1).
REQ-022 On fall with game_status=0: ground_position SHALL hold.
REQ-023 px SHALL have latency 1: if game_status=1 and Y_TOP <= row_addr < Y_TOP+TILE_ROWS, px <= pattern[row_addr-Y_TOP][(col_addr+ground_position) mod TILE_W]; otherwise px <= 0.
REQ-024 The px lookup SHALL use the ground_position value registered before the current edge.
REQ-025 Frame counter (width clog2(SPEED_STEP_FRAMES)) SHALL increment on each fall with game_status=1; on reaching SPEED_STEP_FRAMES-1 with a fall it wraps to 0 and speed increments, saturating at SPEED_MAX.
REQ-026 When game_status=0: speed <= 1 and frame counter <= 0 every cycle.
REQ-027 A fall in the same cycle as a speed increment SHALL advance position by the old speed.
REQ-028 pat_we=1 SHALL overwrite row pat_row with pat_data at that edge, regardless of game_status; px reflects it from the next cycle's lookup; pat_row >= TILE_ROWS SHALL be ignored.
REQ-029 Stopping and restarting the game SHALL NOT reload the pattern; only reset does.

Reset
REQ-030 N_rst=0 at a clk edge SHALL set ground_position=0, speed=1, px=0, frame counter=0, fresh_q=1, pattern=DEFAULT_PATTERN.
REQ-031 Reset SHALL override pat_we and fall in the same cycle; reset mid-frame takes effect at that edge with no residual state.

Configuration
REQ-032 Macro GROUND_SPEEDUP_EN defined: speed ramps per REQ-025.
REQ-033 Macro GROUND_SPEEDUP_EN undefined: frame counter absent, speed constant 1 at all times; all other behaviour unchanged.

Verification
REQ-034 Reset, game_status=1, row_addr=402, col_addr=5 -> px=1 one cycle later; row_addr=401 -> px=0.
REQ-035 game_status=1, speed=1, ground_position=39, one fresh falling edge -> ground_position=0; holding fresh constant for 100 cycles -> no change.
REQ-036 GROUND_SPEEDUP_EN, SPEED_STEP_FRAMES=4: 4 falls -> speed=2; 28 falls -> speed=7 and stays 7 after 8 more; game_status=0 one cycle -> speed=1, counter=0.
REQ-037 pat_we=1, pat_row=0, pat_data=bit 3 only, ground_position=0, game_status=1; then row_addr=400, col_addr=43 -> px=1; col_addr=44 -> px=0.
REQ-038 N_rst=0 asserted together with fall and pat_we, ground_position=17, speed=5 -> next cycle ground_position=0, speed=1, px=0, pattern equals DEFAULT_PATTERN.
